// File: rtl/adpll_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adpll_pkg : shared ADPLL widths, typedefs and saturating clamp helper     |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
package adpll_pkg;

  localparam int ERROR_WIDTH = 5;
  localparam int CTRL_WIDTH  = 8;
  localparam int ACC_WIDTH   = 12;

  typedef logic signed [ERROR_WIDTH-1:0] error_t;
  typedef logic signed [CTRL_WIDTH-1:0]  ctrl_t;

  // Clamp a signed value to the range of a signed word of the given width.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi)      sat_signed = hi;
    else if (value < lo) sat_signed = lo;
    else                 sat_signed = value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/loop_filter_pi_lock_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lock_detector : counts consecutive small-error samples, flags lock        |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module lock_detector #(
  parameter int ERROR_WIDTH = 5,
  parameter int LOCK_THRESH = 2,
  parameter int LOCK_COUNT  = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          sample_i,
  input  logic signed [ERROR_WIDTH-1:0] error_i,
  output logic                          locked_o
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(LOCK_COUNT);
  localparam logic [ERROR_WIDTH:0] THRESH  = (ERROR_WIDTH + 1)'(LOCK_THRESH);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    locked_q, locked_d;
  logic signed [ERROR_WIDTH:0] err_ext;
  logic [ERROR_WIDTH:0]    mag;
  logic                    in_lock;

  // One extra bit so the most negative error has a representable magnitude.
  always_comb begin
    err_ext  = {error_i[ERROR_WIDTH-1], error_i};
    mag      = err_ext[ERROR_WIDTH] ? $unsigned(-err_ext) : $unsigned(err_ext);
    in_lock  = (mag <= THRESH);
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (sample_i) begin
      if (!in_lock)             cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      locked_d = (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked_o = locked_q;

endmodule
`default_nettype wire

// File: rtl/loop_filter_pi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | loop_filter_pi : two-stage PI loop filter with anti-windup for the ADPLL  |
// | Optional lock detector: define LOOP_FILTER_LOCK_DETECT_EN. Revision 1.0   |
// +--------------------------------------------------------------------------+
module loop_filter_pi
  import adpll_pkg::*;
#(
  parameter int ERROR_WIDTH = adpll_pkg::ERROR_WIDTH,
  parameter int KP_SHIFT    = 2,
  parameter int KI_SHIFT    = 4,
  parameter int ACC_WIDTH   = adpll_pkg::ACC_WIDTH,
  parameter int CTRL_WIDTH  = adpll_pkg::CTRL_WIDTH,
  parameter int LOCK_THRESH = 2,
  parameter int LOCK_COUNT  = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic signed [ERROR_WIDTH-1:0] error_i,
  input  logic                          error_valid_i,
  input  logic                          hold_i,
  output logic signed [CTRL_WIDTH-1:0]  ctrl_o,
  output logic                          ctrl_valid_o,
  output logic                          sat_o,
  output logic                          locked_o
);

  localparam int SUM_W = ((ACC_WIDTH > ERROR_WIDTH + KP_SHIFT) ?
                          ACC_WIDTH : ERROR_WIDTH + KP_SHIFT) + 1;

  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [ERROR_WIDTH-1:0] e_q, e_d;
  logic                          v1_q, v1_d;
  logic signed [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;
  logic                          ctrl_valid_q, ctrl_valid_d;
  logic                          sat_q, sat_d;

  logic signed [31:0]            acc_sum;
  logic signed [ACC_WIDTH-1:0]   acc_next;
  logic                          anti_windup;
  logic signed [SUM_W-1:0]       sum;
  logic signed [31:0]            ctrl_full;

  always_comb begin
    acc_sum  = 32'(acc_q) + 32'(error_i);
    acc_next = ACC_WIDTH'(sat_signed(acc_sum, ACC_WIDTH));
    // Stop integrating further into a rail the output is already pinned at.
    anti_windup = sat_q && (error_i[ERROR_WIDTH-1] == ctrl_q[CTRL_WIDTH-1]);

    acc_d = acc_q;
    e_d   = e_q;
    v1_d  = 1'b0;
    if (error_valid_i) begin
      e_d  = error_i;
      v1_d = 1'b1;
      if (!hold_i && !anti_windup) acc_d = acc_next;
    end

    // acc_q already holds this sample's contribution when v1_q is set.
    sum       = SUM_W'((32'(acc_q) >>> KI_SHIFT) + (32'(e_q) <<< KP_SHIFT));
    ctrl_full = sat_signed(32'(sum), CTRL_WIDTH);

    ctrl_d       = ctrl_q;
    sat_d        = sat_q;
    ctrl_valid_d = v1_q;
    if (v1_q) begin
      ctrl_d = CTRL_WIDTH'(ctrl_full);
      sat_d  = (ctrl_full != 32'(sum));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q        <= '0;
      e_q          <= '0;
      v1_q         <= 1'b0;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      e_q          <= e_d;
      v1_q         <= v1_d;
      ctrl_q       <= ctrl_d;
      ctrl_valid_q <= ctrl_valid_d;
      sat_q        <= sat_d;
    end
  end

  assign ctrl_o       = ctrl_q;
  assign ctrl_valid_o = ctrl_valid_q;
  assign sat_o        = sat_q;

`ifdef LOOP_FILTER_LOCK_DETECT_EN
  lock_detector #(
    .ERROR_WIDTH (ERROR_WIDTH),
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_COUNT  (LOCK_COUNT)
  ) u_lock_detector (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .sample_i (v1_q),
    .error_i  (e_q),
    .locked_o (locked_o)
  );
`else
  assign locked_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_loop_filter_pi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_loop_filter_pi : directed self-checking bench for loop_filter_pi       |
// | Revision          : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_loop_filter_pi;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic signed [4:0] error_i = '0;
  logic              error_valid_i = 1'b0;
  logic              hold_i = 1'b0;
  logic signed [7:0] ctrl_o;
  logic              ctrl_valid_o;
  logic              sat_o;
  logic              locked_o;

  int n_cmp  = 0;
  int n_fail = 0;

  loop_filter_pi dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .error_i       (error_i),
    .error_valid_i (error_valid_i),
    .hold_i        (hold_i),
    .ctrl_o        (ctrl_o),
    .ctrl_valid_o  (ctrl_valid_o),
    .sat_o         (sat_o),
    .locked_o      (locked_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_i       = 1'b1;
    error_valid_i = 1'b0;
    hold_i        = 1'b0;
    error_i       = '0;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
  endtask

  // One isolated sample; returns right after its output edge.
  task automatic sample(input int e, input bit h);
    error_i       = 5'(e);
    hold_i        = h;
    error_valid_i = 1'b1;
    tick();
    error_valid_i = 1'b0;
    hold_i        = 1'b0;
    tick();
    chk("pulse", int'(ctrl_valid_o), 1);
  endtask

  task automatic expect_out(input string tag, input int c, input int s);
    chk({tag, "_ctrl"}, int'(ctrl_o), c);
    chk({tag, "_sat"}, int'(sat_o), s);
  endtask

  initial begin
    // Reset and idle
    do_reset();
    repeat (4) tick();
    expect_out("reset", 0, 0);
    chk("reset_valid", int'(ctrl_valid_o), 0);
    chk("reset_locked", int'(locked_o), 0);

    // Single samples, latency and one-cycle pulse
    error_i = 5'sd1;
    error_valid_i = 1'b1;
    tick();
    error_valid_i = 1'b0;
    chk("lat_early", int'(ctrl_valid_o), 0);
    tick();
    chk("lat_pulse", int'(ctrl_valid_o), 1);
    expect_out("single_p1", 4, 0);
    tick();
    chk("pulse_width", int'(ctrl_valid_o), 0);
    chk("ctrl_held", int'(ctrl_o), 4);
    sample(-16, 0);
    expect_out("single_m16", -65, 0);

    // Integration, back-to-back
    do_reset();
    error_i = 5'sd1;
    error_valid_i = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 16) error_valid_i = 1'b0;
      if (c >= 2) begin
        chk("b2b_valid", int'(ctrl_valid_o), 1);
        chk("b2b_ctrl", int'(ctrl_o), (c == 17) ? 5 : 4);
      end
    end
    tick();
    chk("b2b_end", int'(ctrl_valid_o), 0);
    chk("b2b_sat", int'(sat_o), 0);

    // Reset with a sample in flight discards it
    error_i = 5'sd7;
    error_valid_i = 1'b1;
    tick();
    error_valid_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("flush_valid", int'(ctrl_valid_o), 0);
    tick();
    chk("flush_valid2", int'(ctrl_valid_o), 0);
    expect_out("flush", 0, 0);

    // Positive saturation and anti-windup
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      sample(15, 0);
      if (k == 72)  expect_out("psat_k72", 127, 0);
      if (k == 73)  expect_out("psat_k73", 127, 1);
    end
    expect_out("psat_end", 127, 1);
    sample(-16, 0);
    expect_out("psat_rec1", 3, 0);
    sample(-16, 0);
    expect_out("psat_rec2", 2, 0);

    // Negative saturation and floor rounding
    do_reset();
    for (int k = 1; k <= 70; k++) begin
      sample(-16, 0);
      if (k == 64) expect_out("nsat_k64", -128, 0);
      if (k == 65) expect_out("nsat_k65", -128, 1);
    end
    expect_out("nsat_end", -128, 1);
    sample(15, 0);
    expect_out("nsat_rec", -5, 0);

    // Hold
    do_reset();
    sample(15, 0);
    sample(15, 0);
    sample(2, 0);
    expect_out("hold_pre", 10, 0);
    for (int k = 1; k <= 10; k++) begin
      sample(4, 1);
      chk("hold_ctrl", int'(ctrl_o), 18);
    end
    sample(4, 0);
    expect_out("hold_rel", 18, 0);
    sample(15, 0);
    expect_out("hold_after", 63, 0);

`ifdef LOOP_FILTER_LOCK_DETECT_EN
    // Lock detection
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      sample(0, 0);
      chk("lock_rise", int'(locked_o), (k == 64) ? 1 : 0);
    end
    sample(2, 0);
    chk("lock_thr_p2", int'(locked_o), 1);
    sample(-2, 0);
    chk("lock_thr_m2", int'(locked_o), 1);
    sample(3, 0);
    chk("lock_drop_p3", int'(locked_o), 0);
    for (int k = 1; k <= 64; k++) sample(0, 0);
    chk("lock_again", int'(locked_o), 1);
    sample(-16, 0);
    chk("lock_drop_m16", int'(locked_o), 0);
    for (int k = 1; k <= 40; k++) sample(0, 0);
    do_reset();
    chk("lock_reset", int'(locked_o), 0);
    for (int k = 1; k <= 64; k++) begin
      sample(0, 0);
      if (k >= 63) chk("lock_restart", int'(locked_o), (k == 64) ? 1 : 0);
    end
`else
    for (int k = 1; k <= 70; k++) sample(0, 0);
    chk("lock_tied", int'(locked_o), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
